// File: rtl/fp_mul_scheduler_if.sv
// Bundle between the multiplier scheduler, its requesters, the shared multiplier
// and the response consumer. The slave view belongs to the scheduler.
interface fp_mul_scheduler_if #(
    parameter int unsigned N_REQ = 4
);
    localparam int unsigned OP_W   = 32;
    localparam int unsigned ID_W   = 3;
    localparam int unsigned FLAG_W = 3;

    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [OP_W*N_REQ-1:0] req_a;
    logic [OP_W*N_REQ-1:0] req_b;

    logic [OP_W-1:0]       mul_a;
    logic [OP_W-1:0]       mul_b;
    logic [OP_W-1:0]       mul_product;
    logic                  mul_infinity;
    logic                  mul_nan;
    logic                  mul_overflow;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [OP_W-1:0]       rsp_product;
    logic [FLAG_W-1:0]     rsp_flags;

    logic                  busy;

    modport master (
        output req_valid, req_a, req_b,
        output mul_product, mul_infinity, mul_nan, mul_overflow,
        output rsp_ready,
        input  req_ready, mul_a, mul_b,
        input  rsp_valid, rsp_id, rsp_product, rsp_flags, busy
    );

    modport slave (
        input  req_valid, req_a, req_b,
        input  mul_product, mul_infinity, mul_nan, mul_overflow,
        input  rsp_ready,
        output req_ready, mul_a, mul_b,
        output rsp_valid, rsp_id, rsp_product, rsp_flags, busy
    );
endinterface

// File: rtl/fp_mul_scheduler.sv
// Round-robin scheduler sharing one combinational FP32 multiplier among N_REQ
// requesters; holds operands for WAIT_CYCLES, then returns the tagged result.
module fp_mul_scheduler #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    fp_mul_scheduler_if.slave bus
);
    localparam int unsigned OP_W    = 32;
    localparam int unsigned ID_W    = 3;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned SCAN_W  = 4;
    localparam int unsigned MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [CNT_W-1:0]   cnt;

    logic [MAX_REQ-1:0] valid_pad;
    logic [OP_W-1:0]    op_a [MAX_REQ];
    logic [OP_W-1:0]    op_b [MAX_REQ];
    logic [SCAN_W-1:0]  scan_idx;
    logic               grant_any;
    logic [ID_W-1:0]    grant_id;
    logic [N_REQ-1:0]   grant;

    // Pad requester lanes to the full id space so a 3-bit id indexes them directly.
    assign valid_pad = MAX_REQ'(bus.req_valid);

    for (genvar i = 0; i < MAX_REQ; i++) begin : g_ops
        if (i < N_REQ) begin : g_used
            assign op_a[i] = bus.req_a[OP_W*i +: OP_W];
            assign op_b[i] = bus.req_b[OP_W*i +: OP_W];
        end else begin : g_pad
            assign op_a[i] = '0;
            assign op_b[i] = '0;
        end
    end

    // First valid requester after the last winner, wrapping modulo N_REQ.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        scan_idx  = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            scan_idx = SCAN_W'(rr_ptr) + SCAN_W'(k);
            if (scan_idx >= SCAN_W'(N_REQ)) begin
                scan_idx = scan_idx - SCAN_W'(N_REQ);
            end
            if (!grant_any && valid_pad[scan_idx[ID_W-1:0]]) begin
                grant_any = 1'b1;
                grant_id  = scan_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            grant[i] = grant_any && (grant_id == ID_W'(i));
        end
    end

    // Grant is only offered from IDLE and is held low throughout reset.
    assign bus.req_ready = ((state == IDLE) && !rst) ? grant : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            rr_ptr          <= ID_W'(N_REQ - 1);
            cnt             <= '0;
            bus.mul_a       <= '0;
            bus.mul_b       <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_id      <= '0;
            bus.rsp_product <= '0;
            bus.rsp_flags   <= '0;
            bus.busy        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_any) begin
                        bus.mul_a  <= op_a[grant_id];
                        bus.mul_b  <= op_b[grant_id];
                        bus.rsp_id <= grant_id;
                        rr_ptr     <= grant_id;
                        cnt        <= CNT_W'(WAIT_CYCLES - 1);
                        bus.busy   <= 1'b1;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        bus.rsp_product <= bus.mul_product;
                        bus.rsp_flags   <= {bus.mul_nan, bus.mul_infinity, bus.mul_overflow};
                        bus.rsp_valid   <= 1'b1;
                        state           <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fp_mul_scheduler.sv
// Bench for fp_mul_scheduler: a 4-requester/1-cycle instance and a
// 2-requester/3-cycle instance, each against a cycle-level round-robin model.
module tb_fp_mul_scheduler;
    localparam int unsigned NA = 4;
    localparam int unsigned WA = 1;
    localparam int unsigned NB = 2;
    localparam int unsigned WB = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_mul_scheduler_if #(.N_REQ(NA)) bus_a ();
    fp_mul_scheduler_if #(.N_REQ(NB)) bus_b ();

    fp_mul_scheduler #(.N_REQ(NA), .WAIT_CYCLES(WA)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    fp_mul_scheduler #(.N_REQ(NB), .WAIT_CYCLES(WB)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    // Stand-in multiplier: known IEEE products, {nan, inf, ovf, product}.
    function automatic logic [34:0] mul_stub(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h42AA4000, 32'h42348000}: return {3'b000, 32'h45701440};
            {32'hC0B00000, 32'h40C80000}: return {3'b000, 32'hC2098000};
            {32'h42AA4000, 32'h00000000}: return {3'b000, 32'h00000000};
            {32'h40D00000, 32'h40400000}: return {3'b000, 32'h419C0000};
            {32'h7FC00000, 32'h3F800000}: return {3'b100, 32'h7FC00000};
            {32'h7F000000, 32'h7F000000}: return {3'b011, 32'h7F800000};
            default:                      return {3'b000, a ^ {b[15:0], b[31:16]}};
        endcase
    endfunction

    assign {bus_a.mul_nan, bus_a.mul_infinity, bus_a.mul_overflow, bus_a.mul_product} = mul_stub(bus_a.mul_a, bus_a.mul_b);
    assign {bus_b.mul_nan, bus_b.mul_infinity, bus_b.mul_overflow, bus_b.mul_product} = mul_stub(bus_b.mul_a, bus_b.mul_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a server that is either free or holding one job of a given age.
    bit          m_busy [2];
    int          m_age  [2];
    int          m_last [2];
    logic [31:0] m_a    [2];
    logic [31:0] m_b    [2];
    int          m_id   [2];

    task automatic model_step(input int k, input int n, input int w,
                              input logic [7:0] valid, input logic [7:0] ready,
                              input logic [255:0] ra, input logic [255:0] rb,
                              input logic [31:0] ma, input logic [31:0] mb,
                              input logic rv, input logic rr, input logic [2:0] rid,
                              input logic [31:0] rp, input logic [2:0] rf, input logic bsy);
        logic [7:0]  exp_ready;
        logic [34:0] r;
        int          win;
        string       p;
        p = (k == 0) ? "a" : "b";
        if (rst) begin
            chk({p, ".rst req_ready"}, 32'(ready), 0);
            chk({p, ".rst busy"}, 32'(bsy), 0);
            chk({p, ".rst rsp_valid"}, 32'(rv), 0);
            chk({p, ".rst mul_a"}, ma, 0);
            chk({p, ".rst mul_b"}, mb, 0);
            chk({p, ".rst rsp_id"}, 32'(rid), 0);
            chk({p, ".rst rsp_product"}, rp, 0);
            chk({p, ".rst rsp_flags"}, 32'(rf), 0);
            m_busy[k] = 1'b0;
            m_age[k]  = 0;
            m_last[k] = n - 1;
            return;
        end
        exp_ready = '0;
        win = -1;
        if (!m_busy[k]) begin
            for (int s = 1; s <= n; s++) begin
                int c;
                c = (m_last[k] + s) % n;
                if (win < 0 && valid[c]) win = c;
            end
        end
        if (win >= 0) exp_ready[win] = 1'b1;
        chk({p, ".req_ready"}, 32'(ready), 32'(exp_ready));
        chk({p, ".busy"}, 32'(bsy), 32'(m_busy[k]));
        chk({p, ".rsp_valid"}, 32'(rv), 32'(m_busy[k] && m_age[k] >= w));
        if (m_busy[k]) begin
            chk({p, ".mul_a"}, ma, m_a[k]);
            chk({p, ".mul_b"}, mb, m_b[k]);
            if (m_age[k] >= w) begin
                r = mul_stub(m_a[k], m_b[k]);
                chk({p, ".rsp_id"}, 32'(rid), 32'(m_id[k]));
                chk({p, ".rsp_product"}, rp, r[31:0]);
                chk({p, ".rsp_flags"}, 32'(rf), 32'(r[34:32]));
            end
        end
        if (win >= 0) begin
            m_busy[k] = 1'b1;
            m_age[k]  = 0;
            m_a[k]    = ra[32*win +: 32];
            m_b[k]    = rb[32*win +: 32];
            m_id[k]   = win;
            m_last[k] = win;
        end else if (m_busy[k]) begin
            if (m_age[k] >= w && rr) m_busy[k] = 1'b0;
            else m_age[k]++;
        end
    endtask

    always @(negedge clk)
        model_step(0, NA, WA, 8'(bus_a.req_valid), 8'(bus_a.req_ready), 256'(bus_a.req_a), 256'(bus_a.req_b),
                   bus_a.mul_a, bus_a.mul_b, bus_a.rsp_valid, bus_a.rsp_ready, bus_a.rsp_id,
                   bus_a.rsp_product, bus_a.rsp_flags, bus_a.busy);
    always @(negedge clk)
        model_step(1, NB, WB, 8'(bus_b.req_valid), 8'(bus_b.req_ready), 256'(bus_b.req_a), 256'(bus_b.req_b),
                   bus_b.mul_a, bus_b.mul_b, bus_b.rsp_valid, bus_b.rsp_ready, bus_b.rsp_id,
                   bus_b.rsp_product, bus_b.rsp_flags, bus_b.busy);

    // Handshakes as seen on the DUT ports, stamped with the cycle before the edge.
    int acc_id_a[$], acc_cyc_a[$], rsp_id_a[$], rsp_cyc_a[$];
    int acc_id_b[$], acc_cyc_b[$], rsp_id_b[$], rsp_cyc_b[$];

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NA; i++)
                if (bus_a.req_valid[i] && bus_a.req_ready[i]) begin
                    acc_id_a.push_back(i);
                    acc_cyc_a.push_back(cyc);
                end
            for (int i = 0; i < NB; i++)
                if (bus_b.req_valid[i] && bus_b.req_ready[i]) begin
                    acc_id_b.push_back(i);
                    acc_cyc_b.push_back(cyc);
                end
            if (bus_a.rsp_valid && bus_a.rsp_ready) begin
                rsp_id_a.push_back(int'(bus_a.rsp_id));
                rsp_cyc_a.push_back(cyc);
            end
            if (bus_b.rsp_valid && bus_b.rsp_ready) begin
                rsp_id_b.push_back(int'(bus_b.rsp_id));
                rsp_cyc_b.push_back(cyc);
            end
        end
    end

    task automatic set_req(input int k, input int i, input logic [31:0] a, input logic [31:0] b, input logic v);
        if (k == 0) begin
            bus_a.req_a[32*i +: 32] = a;
            bus_a.req_b[32*i +: 32] = b;
            bus_a.req_valid[i]      = v;
        end else begin
            bus_b.req_a[32*i +: 32] = a;
            bus_b.req_b[32*i +: 32] = b;
            bus_b.req_valid[i]      = v;
        end
    endtask

    function automatic logic ready_bit(input int k, input int i);
        return (k == 0) ? bus_a.req_ready[i] : bus_b.req_ready[i];
    endfunction

    function automatic logic rv_of(input int k);
        return (k == 0) ? bus_a.rsp_valid : bus_b.rsp_valid;
    endfunction

    function automatic logic busy_of(input int k);
        return (k == 0) ? bus_a.busy : bus_b.busy;
    endfunction

    // Raise a request, drop it after its grant edge, optionally count edges to rsp_valid.
    task automatic issue(input int k, input int i, input logic [31:0] a, input logic [31:0] b,
                         input bit wait_rsp, output int lat);
        int t;
        set_req(k, i, a, b, 1'b1);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!ready_bit(k, i) && t < 50);
        chk($sformatf("grant k%0d r%0d", k, i), 32'(ready_bit(k, i)), 1);
        @(posedge clk);
        #1;
        set_req(k, i, a, b, 1'b0);
        lat = 0;
        if (wait_rsp) begin
            while (!rv_of(k) && lat < 50) begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
    endtask

    task automatic wait_idle(input int k);
        int t;
        t = 0;
        while (busy_of(k) && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk($sformatf("idle k%0d", k), 32'(busy_of(k)), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int s0;
        int r0;
        int t;
        int fair_exp[6];
        int alt_exp[4];
        fair_exp = '{0, 1, 2, 3, 0, 1};
        alt_exp  = '{1, 0, 1, 0};

        bus_a.req_valid = '0; bus_a.req_a = '0; bus_a.req_b = '0; bus_a.rsp_ready = 1'b1;
        bus_b.req_valid = '0; bus_b.req_a = '0; bus_b.req_b = '0; bus_b.rsp_ready = 1'b1;

        // Reset with a request already pending: no grant may leak through.
        #1 rst = 1'b1;
        set_req(0, 0, 32'h42AA4000, 32'h42348000, 1'b1);
        repeat (3) @(negedge clk);
        chk("reset req_ready", 32'(bus_a.req_ready), 0);
        chk("reset busy", 32'(bus_a.busy), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        issue(0, 0, 32'h42AA4000, 32'h42348000, 1'b1, lat);
        chk("t1 latency", 32'(lat), WA);
        chk("t1 product", bus_a.rsp_product, 32'h45701440);
        chk("t1 id", 32'(bus_a.rsp_id), 0);
        chk("t1 flags", 32'(bus_a.rsp_flags), 0);
        wait_idle(0);

        issue(0, 2, 32'hC0B00000, 32'h40C80000, 1'b1, lat);
        chk("neg product", bus_a.rsp_product, 32'hC2098000);
        chk("neg id", 32'(bus_a.rsp_id), 2);
        wait_idle(0);

        issue(0, 1, 32'h42AA4000, 32'h00000000, 1'b1, lat);
        chk("zero product", bus_a.rsp_product, 32'h00000000);
        chk("zero id", 32'(bus_a.rsp_id), 1);
        wait_idle(0);

        issue(0, 3, 32'h7FC00000, 32'h3F800000, 1'b1, lat);
        chk("nan product", bus_a.rsp_product, 32'h7FC00000);
        chk("nan flags", 32'(bus_a.rsp_flags), 32'b100);
        wait_idle(0);

        issue(0, 3, 32'h7F000000, 32'h7F000000, 1'b1, lat);
        chk("ovf product", bus_a.rsp_product, 32'h7F800000);
        chk("ovf flags", 32'(bus_a.rsp_flags), 32'b011);
        wait_idle(0);

        // All four requesters held valid.
        s0 = acc_id_a.size();
        r0 = rsp_id_a.size();
        set_req(0, 0, 32'h42AA4000, 32'h42348000, 1'b1);
        set_req(0, 1, 32'hC0B00000, 32'h40C80000, 1'b1);
        set_req(0, 2, 32'h40D00000, 32'h40400000, 1'b1);
        set_req(0, 3, 32'h7F000000, 32'h7F000000, 1'b1);
        t = 0;
        while (acc_id_a.size() < s0 + 6 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        bus_a.req_valid = '0;
        chk("fair grants", 32'(acc_id_a.size() >= s0 + 6), 1);
        wait_idle(0);
        for (int j = 0; j < 6; j++)
            chk($sformatf("fair order %0d", j), 32'(rsp_id_a[r0+j]), 32'(fair_exp[j]));
        for (int j = 1; j < 6; j++)
            chk($sformatf("fair interval %0d", j), 32'(acc_cyc_a[s0+j] - acc_cyc_a[s0+j-1]), WA + 2);

        // Backpressure with requesters 0 and 2 waiting; pointer sits at 1 so 2 wins.
        bus_a.rsp_ready = 1'b0;
        set_req(0, 0, 32'h42AA4000, 32'h42348000, 1'b1);
        set_req(0, 2, 32'hC0B00000, 32'h40C80000, 1'b1);
        t = 0;
        while (!bus_a.rsp_valid && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        set_req(0, 2, 32'hC0B00000, 32'h40C80000, 1'b0);
        chk("bp rsp_valid", 32'(bus_a.rsp_valid), 1);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk($sformatf("bp hold valid %0d", j), 32'(bus_a.rsp_valid), 1);
            chk($sformatf("bp hold product %0d", j), bus_a.rsp_product, 32'hC2098000);
            chk($sformatf("bp hold id %0d", j), 32'(bus_a.rsp_id), 2);
            chk($sformatf("bp hold ready %0d", j), 32'(bus_a.req_ready), 0);
            chk($sformatf("bp hold busy %0d", j), 32'(bus_a.busy), 1);
        end
        @(posedge clk);
        #1 bus_a.rsp_ready = 1'b1;
        s0 = acc_id_a.size();
        t = 0;
        while (acc_id_a.size() <= s0 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        set_req(0, 0, 32'h42AA4000, 32'h42348000, 1'b0);
        chk("bp next id", 32'(acc_id_a[s0]), 0);
        chk("bp next gap", 32'(acc_cyc_a[s0] - rsp_cyc_a[rsp_cyc_a.size()-1]), 1);
        wait_idle(0);

        // Reset while the job is settling.
        issue(0, 0, 32'h42AA4000, 32'h42348000, 1'b0, lat);
        chk("settle mul_a", bus_a.mul_a, 32'h42AA4000);
        chk("settle busy", 32'(bus_a.busy), 1);
        #1 rst = 1'b1;
        #1;
        chk("async mul_a", bus_a.mul_a, 0);
        chk("async mul_b", bus_a.mul_b, 0);
        chk("async busy", 32'(bus_a.busy), 0);
        chk("async rsp_valid", 32'(bus_a.rsp_valid), 0);
        chk("async rsp_product", bus_a.rsp_product, 0);
        chk("async req_ready", 32'(bus_a.req_ready), 0);
        r0 = rsp_id_a.size();
        set_req(0, 0, 32'h42AA4000, 32'h42348000, 1'b1);
        set_req(0, 3, 32'h7F000000, 32'h7F000000, 1'b1);
        repeat (3) @(posedge clk);
        chk("no discarded rsp", 32'(rsp_id_a.size()), 32'(r0));
        @(posedge clk);
        #1 rst = 1'b0;
        s0 = acc_id_a.size();
        t = 0;
        while (acc_id_a.size() <= s0 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        set_req(0, 0, 32'h42AA4000, 32'h42348000, 1'b0);
        chk("post-reset first id", 32'(acc_id_a[s0]), 0);
        t = 0;
        while (acc_id_a.size() <= s0 + 1 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        set_req(0, 3, 32'h7F000000, 32'h7F000000, 1'b0);
        chk("post-reset second id", 32'(acc_id_a[s0+1]), 3);
        wait_idle(0);

        // Two requesters, three settle cycles.
        issue(1, 0, 32'h40D00000, 32'h40400000, 1'b1, lat);
        chk("b latency", 32'(lat), WB);
        chk("b product", bus_b.rsp_product, 32'h419C0000);
        chk("b id", 32'(bus_b.rsp_id), 0);
        wait_idle(1);

        s0 = acc_id_b.size();
        r0 = rsp_id_b.size();
        set_req(1, 0, 32'h40D00000, 32'h40400000, 1'b1);
        set_req(1, 1, 32'hC0B00000, 32'h40C80000, 1'b1);
        t = 0;
        while (acc_id_b.size() < s0 + 4 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        bus_b.req_valid = '0;
        chk("b grants", 32'(acc_id_b.size() >= s0 + 4), 1);
        wait_idle(1);
        for (int j = 0; j < 4; j++)
            chk($sformatf("b alt order %0d", j), 32'(rsp_id_b[r0+j]), 32'(alt_exp[j]));
        for (int j = 1; j < 4; j++)
            chk($sformatf("b interval %0d", j), 32'(acc_cyc_b[s0+j] - acc_cyc_b[s0+j-1]), WB + 2);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_mul_scheduler.md
# fp_mul_scheduler

Round-robin scheduler that shares one combinational single-precision floating-point multiplier among up to 8 requesters.
- Each accepted request has its operands registered onto the multiplier inputs.
- The scheduler waits a parameterised settle time, then captures the product and status flags.
- It returns the result, tagged with the requester index, over a valid/ready response port.
- It sits between requester blocks and the shared multiplier instance at the top level.

## Interface
- N_REQ, 4, number of requesters (legal 2..8)
- WAIT_CYCLES, 1, cycles the multiplier inputs are held before capture (legal 1..15)

- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  N_REQ  request valid, one bit per requester
- req_a  in  32*N_REQ  operand A; requester i at [32i+31:32i]
- req_b  in  32*N_REQ  operand B, same packing
- req_ready  out  N_REQ  grant/accept, at most one bit high
- mul_a  out  32  registered operand A to multiplier
- mul_b  out  32  registered operand B to multiplier
- mul_product  in  32  multiplier product
- mul_infinity  in  1  multiplier infinity flag
- mul_nan  in  1  multiplier NaN flag
- mul_overflow  in  1  multiplier overflow flag
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  3  index of requester owning the response
- rsp_product  out  32  captured product
- rsp_flags  out  3  captured {nan, infinity, overflow}
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, SETTLE, RESP.
- Reset values:
  - State is IDLE. rr_ptr = N_REQ-1, so requester 0 wins first.
  - mul_a, mul_b, rsp_product, rsp_flags, rsp_id are all 0. rsp_valid = 0 and busy = 0.
  - req_ready is forced to 0 while rst is high.
- IDLE:
  - req_ready is combinational. It is one-hot on the first requester with req_valid set, searching rr_ptr+1, rr_ptr+2, … modulo N_REQ. It is all-zero if no request is valid.
  - Handshake is req_valid[g] & req_ready[g] at a rising edge. On it:
    - mul_a ← req_a[g], mul_b ← req_b[g], rsp_id ← g, rr_ptr ← g.
    - cnt ← WAIT_CYCLES-1, then go to SETTLE.
- SETTLE:
  - req_ready is all-zero; mul_a and mul_b are held.
  - If cnt==0: rsp_product ← mul_product, rsp_flags ← {mul_nan, mul_infinity, mul_overflow}, rsp_valid ← 1, go to RESP.
  - Otherwise cnt ← cnt-1.
- RESP:
  - req_ready is all-zero. rsp_* are held stable while rsp_valid & !rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid ← 0, go to IDLE. The next grant is issued in the following cycle.
- Product and flags are passed through unmodified; the scheduler does no special-case handling of zero, NaN or infinity.
- Requesters must hold req_valid and their operands until their req_ready is seen. A request withdrawn before grant is simply not served.
- Request arrival during SETTLE/RESP: not granted. Arbitration happens on the next IDLE cycle using the updated rr_ptr.
- rr_ptr wraps: after a grant to N_REQ-1, the search starts at 0.

## Timing
- Handshake at edge E0 → mul_a and mul_b are valid after E0.
- Capture happens at edge E0+WAIT_CYCLES. rsp_valid is high after that edge, so latency is WAIT_CYCLES cycles from accept.
- Minimum issue interval is WAIT_CYCLES+2 cycles, with rsp_ready held high.
- busy rises after E0 and falls after the response handshake edge.
- Reset asserted mid-operation (SETTLE or RESP):
  - All registers return to reset values immediately, without waiting for a clock edge.
  - The in-flight result is discarded and no rsp_valid is produced for it.
  - After release, the first grant goes to the lowest-indexed valid requester.
- Simultaneous valid requests: exactly one is granted per IDLE cycle. No requester waits more than N_REQ-1 grants while continuously valid.

## Test plan
- Reset, then single request:
  - During reset all outputs are 0 and req_ready=0.
  - After release, requester 0 issues a=0x42AA4000 (85.125), b=0x42348000 (45.125).
  - Required: rsp_valid high WAIT_CYCLES cycles after accept, rsp_product=0x45701440, rsp_id=0, rsp_flags=0.
- Fairness: all 4 requesters valid continuously with rsp_ready=1 → rsp_id order 0,1,2,3,0,1, with issue interval exactly WAIT_CYCLES+2.
- Sign cases:
  - Requester 2 issues 0xC0B00000 × 0x40C80000 (−5.5×6.25). Required: rsp_product=0xC2098000, rsp_id=2.
  - Requester 1 issues 0x42AA4000 × 0x00000000. Required: rsp_product=0x00000000.
- Backpressure: hold rsp_ready low 5 cycles during RESP with other requests pending → rsp_* stable, req_ready all-zero, busy=1. After rsp_ready rises, the next grant occurs on the following cycle.
- Reset mid-SETTLE: assert rst one cycle after a grant → outputs reach reset values without a clock edge, and no rsp_valid appears. After release with requesters 0 and 3 valid, requester 0 is granted first.
- Parameter variant, WAIT_CYCLES=3 and N_REQ=2:
  - Request 0x40D00000 × 0x40400000 (6.5×3). Required: rsp_product=0x419C0000, rsp_valid exactly 3 cycles after accept.
  - Alternating grants between requesters 0 and 1.
